// File: rtl/div_sched_if.sv
// Requester/consumer bundle for the shared-divider scheduler: per-lane request
// handshake with packed operands, plus the single tagged response port.
interface div_sched_if #(
    parameter int DATA_W = 32,
    parameter int N_REQ  = 4
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        req_sign;
    logic [N_REQ*DATA_W-1:0] req_dividend;
    logic [N_REQ*DATA_W-1:0] req_divisor;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [DATA_W-1:0]       rsp_quotient;
    logic [DATA_W-1:0]       rsp_remainder;
    logic                    rsp_div0;

    modport master (
        output req_valid, req_sign, req_dividend, req_divisor, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_div0
    );

    modport slave (
        input  req_valid, req_sign, req_dividend, req_divisor, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_div0
    );
endinterface

// File: rtl/div_sched.sv
// Round-robin arbiter sharing one sequential divider; div_en the cycle after accept, response the cycle after div_done.
// req_ready only while idle (one grant in flight); the response is held stable until rsp_ready.
module div_sched #(
    parameter int DATA_W = 32,
    parameter int N_REQ  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    div_sched_if.slave        bus,
    output logic              div_en,
    output logic              div_sign,
    output logic [DATA_W-1:0] div_dividend,
    output logic [DATA_W-1:0] div_divisor,
    input  logic              div_done,
    input  logic [DATA_W-1:0] div_quotient,
    input  logic [DATA_W-1:0] div_remainder
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   last_q;
    logic [ID_W-1:0]   id_q;
    logic              sign_q;
    logic [DATA_W-1:0] dvd_q;
    logic [DATA_W-1:0] dvs_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] rem_q;
    logic              div0_q;

    logic              gnt_found;
    logic [ID_W-1:0]   gnt_idx;
    logic [ID_W-1:0]   cand_idx;
    int                cand;
    logic              sel_sign;
    logic [DATA_W-1:0] sel_dvd;
    logic [DATA_W-1:0] sel_dvs;
    logic              sel_zero;

    // Search starts one past the previous winner so every lane gets a turn.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = int'(last_q) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = ID_W'(cand);
            if (!gnt_found && bus.req_valid[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

    assign sel_sign = bus.req_sign[gnt_idx];
    assign sel_dvd  = bus.req_dividend[int'(gnt_idx)*DATA_W +: DATA_W];
    assign sel_dvs  = bus.req_divisor[int'(gnt_idx)*DATA_W +: DATA_W];
    assign sel_zero = (sel_dvs == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (gnt_found) begin
                    state_nxt = sel_zero ? RESP : RUN;
                end
            end
            RUN: begin
                if (div_done) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        div_en        = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_found) begin
                    bus.req_ready[gnt_idx] = 1'b1;
                end
            end
            RUN:     div_en        = 1'b1;
            RESP:    bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // A zero divisor never reaches the divider; its fixed result is loaded at grant time.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= ID_W'(N_REQ - 1);
            id_q   <= '0;
            sign_q <= 1'b0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            div0_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        last_q <= gnt_idx;
                        id_q   <= gnt_idx;
                        sign_q <= sel_sign;
                        dvd_q  <= sel_dvd;
                        dvs_q  <= sel_dvs;
                        if (sel_zero) begin
                            quo_q  <= '1;
                            rem_q  <= sel_dvd;
                            div0_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (div_done) begin
                        quo_q  <= div_quotient;
                        rem_q  <= div_remainder;
                        div0_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_sign          = sign_q;
    assign div_dividend      = dvd_q;
    assign div_divisor       = dvs_q;
    assign bus.rsp_id        = id_q;
    assign bus.rsp_quotient  = quo_q;
    assign bus.rsp_remainder = rem_q;
    assign bus.rsp_div0      = div0_q;
endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: behavioural divider, directed vector table, corner sequences,
// and randomized traffic against a round-robin/arithmetic reference.
module tb_div_sched;
    localparam int W = 32;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         div_en;
    logic         div_sign;
    logic [W-1:0] div_dividend;
    logic [W-1:0] div_divisor;
    logic         div_done;
    logic [W-1:0] div_quotient;
    logic [W-1:0] div_remainder;

    div_sched_if #(.DATA_W(W), .N_REQ(N)) bus ();

    div_sched #(.DATA_W(W), .N_REQ(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .div_en        (div_en),
        .div_sign      (div_sign),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_done      (div_done),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    always #5 clk = ~clk;

    int n_pass;
    int n_total;
    int en_cycles;
    int op_change;
    int grant_cnt [N];

    function automatic void ref_div(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r, output bit d0);
        if (b == '0) begin
            q = '1; r = a; d0 = 1'b1;
        end else if (s) begin
            q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); d0 = 1'b0;
        end else begin
            q = a / b; r = a % b; d0 = 1'b0;
        end
    endfunction

    // Divider model: latency varies with the low dividend bits; done held while en.
    int unsigned  lat_cnt;
    logic         prev_en;
    logic         prev_s;
    logic [W-1:0] prev_a;
    logic [W-1:0] prev_b;
    always @(posedge clk) begin
        logic [W-1:0] q, r;
        bit d0;
        if (!div_en) begin
            div_done <= 1'b0;
            lat_cnt  <= 0;
        end else if (!div_done) begin
            if (lat_cnt >= 3 + div_dividend[1:0]) begin
                ref_div(div_sign, div_dividend, div_divisor, q, r, d0);
                div_quotient  <= q;
                div_remainder <= r;
                div_done      <= 1'b1;
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end
        if (div_en && prev_en && ({div_sign, div_dividend, div_divisor} != {prev_s, prev_a, prev_b}))
            op_change++;
        prev_en <= div_en;
        prev_s  <= div_sign;
        prev_a  <= div_dividend;
        prev_b  <= div_divisor;
    end

    always @(negedge clk) begin
        if (div_en === 1'b1) en_cycles++;
        for (int k = 0; k < N; k++)
            if (bus.req_ready[k] && bus.req_valid[k]) grant_cnt[k]++;
    end

    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(int id, bit s, logic [W-1:0] a, logic [W-1:0] b);
        bus.req_sign[id]            = s;
        bus.req_dividend[id*W +: W] = a;
        bus.req_divisor[id*W +: W]  = b;
        bus.req_valid[id]           = 1'b1;
    endtask

    task automatic accept(int id);
        int n = 0;
        #1;
        while (!bus.req_ready[id] && n < 200) begin
            tick();
            n++;
        end
        check("grant_wait", bus.req_ready[id], 1'b1);
        tick();
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!bus.rsp_valid && n < 200) begin
            tick();
            n++;
        end
        check("rsp_wait", bus.rsp_valid, 1'b1);
    endtask

    task automatic ack();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("rsp_drop", bus.rsp_valid, 1'b0);
    endtask

    typedef struct {
        int         id;
        bit         sgn;
        logic [W-1:0] a, b, q, r;
        bit         d0;
    } vec_t;

    typedef struct {
        bit         s;
        logic [W-1:0] a, b;
    } op_t;

    op_t ops [N][$];

    // Reference: one division in flight; grants go to the first valid lane after the previous winner.
    task automatic traffic(int per_lane, bit full);
        logic [N-1:0] vld, exp_rdy;
        logic [W-1:0] eq, er;
        bit ed0, busy, idle0;
        int eid, rr, g, left, cyc, ngr;
        bus.req_valid = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) begin
            ops[k].delete();
            for (int j = 0; j < per_lane; j++) begin
                op_t o;
                o.s = 1'($urandom_range(0, 1));
                o.a = $urandom;
                if ($urandom_range(0, 7) == 0) o.b = '0;
                else if ($urandom_range(0, 1) == 1) o.b = $urandom;
                else o.b = $urandom_range(1, 300);
                if (o.s && o.a == 32'h8000_0000 && o.b == 32'hFFFF_FFFF) o.b = 32'd1;
                ops[k].push_back(o);
            end
        end
        left = per_lane * N; busy = 1'b0; rr = N - 1; cyc = 0; ngr = 0; eid = 0;
        eq = '0; er = '0; ed0 = 1'b0;
        while ((left > 0 || busy) && cyc < 20000) begin
            for (int k = 0; k < N; k++) begin
                if (ops[k].size() > 0) begin
                    bus.req_sign[k]            = ops[k][0].s;
                    bus.req_dividend[k*W +: W] = ops[k][0].a;
                    bus.req_divisor[k*W +: W]  = ops[k][0].b;
                    vld[k] = full || ($urandom_range(0, 2) != 0);
                end else begin
                    vld[k] = 1'b0;
                end
            end
            bus.req_valid = vld;
            bus.rsp_ready = full || ($urandom_range(0, 1) != 0);
            #1;
            idle0   = !busy;
            exp_rdy = '0;
            g       = -1;
            if (idle0) begin
                for (int i = 1; i <= N; i++)
                    if (g < 0 && vld[(rr + i) % N]) g = (rr + i) % N;
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            check("rr_ready", bus.req_ready, exp_rdy);
            if (idle0) begin
                check("rsp_idle", bus.rsp_valid, 1'b0);
                if (g >= 0) begin
                    ref_div(ops[g][0].s, ops[g][0].a, ops[g][0].b, eq, er, ed0);
                    eid = g; busy = 1'b1; rr = g;
                    void'(ops[g].pop_front());
                    left--;
                    if (full) check("fair_order", g, ngr % N);
                    ngr++;
                end
            end else if (bus.rsp_valid && bus.rsp_ready) begin
                check("tr_id", bus.rsp_id, eid);
                check("tr_quot", bus.rsp_quotient, eq);
                check("tr_rem", bus.rsp_remainder, er);
                check("tr_div0", bus.rsp_div0, ed0);
                busy = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        check("traffic_done", (left == 0 && !busy), 1'b1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        vecs[0] = '{2, 1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1] = '{1, 1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
        vecs[2] = '{3, 1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1'b1};
        vecs[3] = '{0, 1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1};
        vecs[4] = '{0, 1'b0, 32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  32'hF,          1'b0};
        vecs[5] = '{1, 1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
        vecs[6] = '{2, 1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd2,          32'hFFFF_FFFE,  1'b0};
        vecs[7] = '{3, 1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0};

        bus.req_valid = '0; bus.req_sign = '0; bus.req_dividend = '0; bus.req_divisor = '0;
        bus.rsp_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_req_ready", bus.req_ready, '0);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_div_en", div_en, 1'b0);
        check("rst_div0", bus.rsp_div0, 1'b0);
        check("rst_quot", bus.rsp_quotient, '0);
        check("rst_rem", bus.rsp_remainder, '0);
        check("rst_id", bus.rsp_id, '0);
        check("rst_dividend", div_dividend, '0);
        check("rst_divisor", div_divisor, '0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            vec_t v;
            int g0, e0, n;
            v  = vecs[i];
            g0 = grant_cnt[v.id];
            e0 = en_cycles;
            present(v.id, v.sgn, v.a, v.b);
            accept(v.id);
            if (v.d0) begin
                check("div0_rsp_t1", bus.rsp_valid, 1'b1);
                check("div0_en", div_en, 1'b0);
            end else begin
                check("en_t1", div_en, 1'b1);
                n = 0;
                while (!div_done && n < 100) begin
                    tick();
                    n++;
                end
                check("done_seen", div_done, 1'b1);
                check("en_at_done", div_en, 1'b1);
                check("rsp_before_done", bus.rsp_valid, 1'b0);
                tick();
                check("rsp_after_done", bus.rsp_valid, 1'b1);
                check("en_after_done", div_en, 1'b0);
            end
            wait_rsp();
            check("vec_id", bus.rsp_id, v.id);
            check("vec_quot", bus.rsp_quotient, v.q);
            check("vec_rem", bus.rsp_remainder, v.r);
            check("vec_div0", bus.rsp_div0, v.d0);
            ack();
            check("one_grant", grant_cnt[v.id] - g0, 1);
            if (v.d0) check("div0_no_en", en_cycles - e0, 0);
        end

        // Response backpressure: fields must not move while the consumer stalls.
        present(1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        accept(1);
        wait_rsp();
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", bus.rsp_valid, 1'b1);
            check("bp_quot", bus.rsp_quotient, 32'hFFFF_FFFD);
            check("bp_rem", bus.rsp_remainder, 32'hFFFF_FFFF);
            tick();
        end
        ack();

        // Reset while dividing: result discarded, arbitration pointer back to lane 0.
        present(2, 1'b0, 32'd100, 32'd7);
        accept(2);
        check("mid_run_en", div_en, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mr_div_en", div_en, 1'b0);
        check("mr_rsp_valid", bus.rsp_valid, 1'b0);
        check("mr_req_ready", bus.req_ready, '0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("mr_no_rsp", bus.rsp_valid, 1'b0);
        end
        present(0, 1'b0, 32'd50, 32'd6);
        present(3, 1'b0, 32'd9, 32'd4);
        #1;
        check("mr_first_grant", bus.req_ready, 4'b0001);
        accept(0);
        wait_rsp();
        check("mr_id0", bus.rsp_id, 0);
        check("mr_quot0", bus.rsp_quotient, 32'd8);
        check("mr_rem0", bus.rsp_remainder, 32'd2);
        ack();
        accept(3);
        wait_rsp();
        check("mr_id3", bus.rsp_id, 3);
        check("mr_quot3", bus.rsp_quotient, 32'd2);
        check("mr_rem3", bus.rsp_remainder, 32'd1);
        ack();

        traffic(6, 1'b1);
        traffic(12, 1'b0);

        check("op_stable", op_change, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
